// File: rtl/bpu_update_arbiter_pkg.sv
// Shared types for the BPU training path: the branch-update record that
// flows from commit to the predictor, plus the core widths it depends on.
package bpu_update_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NRET = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            is_cond;
        logic            taken;
        logic            is_call;
        logic            is_ret;
    } bpu_update_t;

endpackage

// File: rtl/bpu_upd_compactor.sv
// Prefix popcount over the commit lanes: each valid lane gets its slot offset
// from the queue tail, so sparse bundles are written without gaps.
module bpu_upd_compactor
    import bpu_update_arbiter_pkg::*;
#(
    parameter int unsigned CW = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]         valid,
    output logic [NRET-1:0][CW-1:0] offset,
    output logic [CW-1:0]           n_enq
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        n_enq = acc;
    end

endmodule

// File: rtl/bpu_update_arbiter.sv
// Program-ordered queue of resolved-branch records feeding the BPU's single
// training port: accepts whole commit bundles, drains one record per cycle.
module bpu_update_arbiter
    import bpu_update_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NRET-1:0]          commit_valid_i,
    input  logic [NRET*XLEN-1:0]     commit_pc_i,
    input  logic [NRET*XLEN-1:0]     commit_target_i,
    input  logic [NRET-1:0]          commit_is_cond_i,
    input  logic [NRET-1:0]          commit_taken_i,
    input  logic [NRET-1:0]          commit_is_call_i,
    input  logic [NRET-1:0]          commit_is_ret_i,
    output logic                     commit_ready_o,
    input  logic                     update_stall_i,
    output logic                     update_valid_o,
    output logic [XLEN-1:0]          update_pc_o,
    output logic [XLEN-1:0]          update_target_o,
    output logic                     update_is_cond_o,
    output logic                     update_taken_o,
    output logic                     update_is_call_o,
    output logic                     update_is_ret_o,
    output logic [$clog2(DEPTH):0]   dbg_count_o,
    output logic [63:0]              dbg_stall_cycles_o
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = $clog2(NRET + 1);

    if (DEPTH < NRET || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bpu_update_arbiter: DEPTH must be a power of two and >= NRET");
    end

    bpu_update_t               mem [DEPTH];
    bpu_update_t               lane [NRET];
    bpu_update_t               head;
    logic [PW-1:0]             head_q, tail_q;
    logic [CNTW-1:0]           count_q, count_d, n_take;
    logic [63:0]               stall_q;
    logic [NRET-1:0][CW-1:0]   offset;
    logic [CW-1:0]             n_enq;
    logic                      deq;

    bpu_upd_compactor #(.CW(CW)) u_compactor (
        .valid  (commit_valid_i),
        .offset (offset),
        .n_enq  (n_enq)
    );

    always_comb begin
        for (int unsigned i = 0; i < NRET; i++) begin
            lane[i] = '{pc:      commit_pc_i[i*XLEN +: XLEN],
                        target:  commit_target_i[i*XLEN +: XLEN],
                        is_cond: commit_is_cond_i[i],
                        taken:   commit_taken_i[i],
                        is_call: commit_is_call_i[i],
                        is_ret:  commit_is_ret_i[i]};
        end
    end

    // Ready looks only at registered occupancy; a same-cycle pop earns no credit.
    assign commit_ready_o = (count_q <= CNTW'(DEPTH - NRET));
    assign deq            = (count_q != '0) && !update_stall_i;
    assign n_take         = commit_ready_o ? CNTW'(n_enq) : '0;
    assign count_d        = count_q + n_take - CNTW'(deq);

    assign head             = (count_q != '0) ? mem[head_q] : '0;
    assign update_valid_o   = deq;
    assign update_pc_o      = head.pc;
    assign update_target_o  = head.target;
    assign update_is_cond_o = head.is_cond;
    assign update_taken_o   = head.taken;
    assign update_is_call_o = head.is_call;
    assign update_is_ret_o  = head.is_ret;

    assign dbg_count_o        = count_q;
    assign dbg_stall_cycles_o = stall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            count_q <= count_d;
            tail_q  <= tail_q + PW'(n_take);
            if (deq) begin
                head_q <= head_q + PW'(1);
            end
            if (|commit_valid_i && !commit_ready_o && stall_q != '1) begin
                stall_q <= stall_q + 64'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && commit_ready_o) begin
            for (int unsigned i = 0; i < NRET; i++) begin
                if (commit_valid_i[i]) begin
                    mem[tail_q + PW'(offset[i])] <= lane[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_bpu_update_arbiter.sv
// Self-checking bench for bpu_update_arbiter: directed vector table, hand
// sequences for wrap and reset-mid-drain, and random traffic against a queue model.
module tb_bpu_update_arbiter;
    import bpu_update_arbiter_pkg::*;

    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRET-1:0]      cv, ccond, ctaken, ccall, cret;
    logic [NRET*XLEN-1:0] cpc, ctgt;
    logic                 ready, stall, uv;
    logic [XLEN-1:0]      upc, utgt;
    logic                 ucond, utaken, ucall, uret;
    logic [3:0]           cnt;
    logic [63:0]          sc;

    always #5 clk = ~clk;

    bpu_update_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .commit_valid_i     (cv),
        .commit_pc_i        (cpc),
        .commit_target_i    (ctgt),
        .commit_is_cond_i   (ccond),
        .commit_taken_i     (ctaken),
        .commit_is_call_i   (ccall),
        .commit_is_ret_i    (cret),
        .commit_ready_o     (ready),
        .update_stall_i     (stall),
        .update_valid_o     (uv),
        .update_pc_o        (upc),
        .update_target_o    (utgt),
        .update_is_cond_o   (ucond),
        .update_taken_o     (utaken),
        .update_is_call_o   (ucall),
        .update_is_ret_o    (uret),
        .dbg_count_o        (cnt),
        .dbg_stall_cycles_o (sc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]       vld;
        logic             stl;
        logic [3:0][31:0] pc;
        logic             rdy;
        logic             uv;
        logic [31:0]      upc;
        int               cnt;
        int               sc;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic stl,
                                input logic [31:0] p0, p1, p2, p3,
                                input logic rdy, input logic v, input logic [31:0] u,
                                input int c, input int s);
        vec_t r;
        r.vld = vld; r.stl = stl;
        r.pc[0] = p0; r.pc[1] = p1; r.pc[2] = p2; r.pc[3] = p3;
        r.rdy = rdy; r.uv = v; r.upc = u; r.cnt = c; r.sc = s;
        return r;
    endfunction

    function automatic vec_t mkb(input logic [3:0] vld, input logic stl, input logic [31:0] b,
                                 input logic rdy, input logic v, input logic [31:0] u,
                                 input int c, input int s);
        return mk(vld, stl, b, b + 32'h4, b + 32'h8, b + 32'hC, rdy, v, u, c, s);
    endfunction

    // Reference model: a plain FIFO of records plus a held-bundle cycle counter.
    bpu_update_t      mq[$];
    longint unsigned  msc;
    logic             m_ready;

    function automatic bpu_update_t lane_rec(input int i);
        bpu_update_t r;
        r.pc      = cpc[i*XLEN +: XLEN];
        r.target  = ctgt[i*XLEN +: XLEN];
        r.is_cond = ccond[i];
        r.taken   = ctaken[i];
        r.is_call = ccall[i];
        r.is_ret  = cret[i];
        return r;
    endfunction

    task automatic model_check();
        bpu_update_t h;
        m_ready = ((DEPTH - mq.size()) >= NRET);
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("rnd_count", 64'(cnt), 64'(mq.size()));
        chk("rnd_ready", 64'(ready), 64'(m_ready));
        chk("rnd_uvalid", 64'(uv), 64'((mq.size() != 0) && !stall));
        chk("rnd_pc", 64'(upc), 64'(h.pc));
        chk("rnd_target", 64'(utgt), 64'(h.target));
        chk("rnd_flags", 64'({ucond, utaken, ucall, uret}),
            64'({h.is_cond, h.taken, h.is_call, h.is_ret}));
        chk("rnd_stall_cycles", sc, msc);
    endtask

    task automatic model_edge();
        if (mq.size() != 0 && !stall) void'(mq.pop_front());
        if (m_ready) begin
            for (int i = 0; i < NRET; i++) if (cv[i]) mq.push_back(lane_rec(i));
        end
        if (|cv && !m_ready && msc != 64'hFFFF_FFFF_FFFF_FFFF) msc++;
    endtask

    task automatic clear_lanes();
        cv = '0; cpc = '0; ctgt = '0; ccond = '0; ctaken = '0; ccall = '0; cret = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete();
        msc = 0;
    endtask

    task automatic set_pcs(input logic [3:0][31:0] p);
        for (int i = 0; i < NRET; i++) cpc[i*XLEN +: XLEN] = p[i];
    endtask

    vec_t tbl[21];

    initial begin
        clear_lanes();
        stall = 1'b0;

        // Reset held two cycles with a full bundle pending
        rst_n = 1'b0;
        cv    = 4'hF;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cv    = '0;
        @(negedge clk);
        chk("reset_count", 64'(cnt), 0);
        chk("reset_ready", 64'(ready), 1);
        chk("reset_uvalid", 64'(uv), 0);
        chk("reset_pc", 64'(upc), 0);
        chk("reset_stall_cycles", sc, 0);
        @(posedge clk); #1;

        // Directed table: compaction, fill to full, backpressure, ready threshold, drain
        tbl[0]  = mk(4'b1010, 0, 0, 32'h100, 0, 32'h200, 1, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h100, 2, 0);
        tbl[2]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h200, 1, 0);
        tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[4]  = mkb(4'hF, 1, 32'h1000, 1, 0, 0, 0, 0);
        tbl[5]  = mkb(4'hF, 1, 32'h2000, 1, 0, 32'h1000, 4, 0);
        tbl[6]  = mkb(4'hF, 1, 32'h3000, 0, 0, 32'h1000, 8, 0);
        tbl[7]  = mkb(4'hF, 1, 32'h3000, 0, 0, 32'h1000, 8, 1);
        tbl[8]  = mkb(4'hF, 0, 32'h3000, 0, 1, 32'h1000, 8, 2);
        tbl[9]  = mkb(4'hF, 0, 32'h3000, 0, 1, 32'h1004, 7, 3);
        tbl[10] = mkb(4'hF, 0, 32'h3000, 0, 1, 32'h1008, 6, 4);
        tbl[11] = mkb(4'hF, 0, 32'h3000, 0, 1, 32'h100C, 5, 5);
        tbl[12] = mkb(4'hF, 0, 32'h3000, 1, 1, 32'h2000, 4, 6);
        tbl[13] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'h2004, 7, 6);
        tbl[14] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'h2008, 6, 6);
        tbl[15] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 1, 32'h200C, 5, 6);
        tbl[16] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h3000, 4, 6);
        tbl[17] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h3004, 3, 6);
        tbl[18] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h3008, 2, 6);
        tbl[19] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 1, 32'h300C, 1, 6);
        tbl[20] = mk(4'b0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6);

        foreach (tbl[i]) begin
            cv    = tbl[i].vld;
            stall = tbl[i].stl;
            set_pcs(tbl[i].pc);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 64'(ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_uvalid", i), 64'(uv), 64'(tbl[i].uv));
            chk($sformatf("tbl%0d_pc", i), 64'(upc), 64'(tbl[i].upc));
            chk($sformatf("tbl%0d_count", i), 64'(cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_stall_cycles", i), sc, 64'(tbl[i].sc));
            @(posedge clk); #1;
        end
        clear_lanes();
        stall = 1'b0;

        // Wrap: 20 two-lane bundles, held by commit whenever not ready
        begin
            int k = 0;
            int got = 0;
            logic r;
            for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
                cv = (k < 20) ? 4'b0011 : 4'b0000;
                cpc[0 +: XLEN]    = 32'h4000 + 32'(8 * k);
                cpc[XLEN +: XLEN] = 32'h4004 + 32'(8 * k);
                @(negedge clk);
                r = ready;
                if (uv) begin
                    chk("wrap_order", 64'(upc), 64'(32'h4000 + 32'(4 * got)));
                    got++;
                end
                @(posedge clk); #1;
                if (k < 20 && r) k++;
            end
            chk("wrap_update_total", 64'(got), 40);
            clear_lanes();
            @(negedge clk);
            chk("wrap_empty_after", 64'(uv), 0);
            @(posedge clk); #1;
        end

        // Reset mid-drain with 6 queued records
        stall = 1'b1;
        cv = 4'hF;    cpc = {32'h500C, 32'h5008, 32'h5004, 32'h5000};
        @(posedge clk); #1;
        cv = 4'b0011; cpc = {32'h0, 32'h0, 32'h6004, 32'h6000};
        @(posedge clk); #1;
        clear_lanes();
        @(negedge clk);
        chk("middrain_count_before", 64'(cnt), 6);
        @(posedge clk); #1;
        stall = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("middrain_uvalid", 64'(uv), 0);
            chk("middrain_count", 64'(cnt), 0);
            chk("middrain_ready", 64'(ready), 1);
            @(posedge clk); #1;
        end

        // Randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cv     = 4'($urandom);
            ccond  = 4'($urandom);
            ctaken = 4'($urandom);
            ccall  = 4'($urandom);
            cret   = 4'($urandom);
            for (int i = 0; i < NRET; i++) begin
                cpc[i*XLEN +: XLEN]  = $urandom;
                ctgt[i*XLEN +: XLEN] = $urandom;
            end
            stall = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end
        clear_lanes();
        stall = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
